cache_set: RTL
==============

# cache_set

Parametrised N-way cache set for the data/instruction cache: per-way tag, valid, dirty and line storage, combinational hit lookup with byte-enabled write-hit, true-LRU replacement, and a sequencer that streams a dirty victim out and a refill line in word by word. It sits between the cache controller (lookup and miss commands) and the AXI bridge (evict/refill word streams). The cache top instantiates one cache_set per index, or one set with external index muxing.

## Interface
Parameters:
- WAYS, 2, number of ways; power of two, 1..8
- CACHE_LINE_WIDTH, 6, log2 bytes per line; OFF_WIDTH = CACHE_LINE_WIDTH-2, ≤ 7
- TAG_WIDTH, 18, tag bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  lookup request this cycle
- req_tag  in  TAG_WIDTH  lookup tag
- req_off  in  OFF_WIDTH  word offset
- req_write  in  1  write-hit request
- req_wdata  in  32  write data
- req_be  in  4  byte enables
- hit  out  1  combinational; req_valid & a valid way tag-matches & state IDLE
- hit_way  out  log2(WAYS) (min 1)  matching way
- rdata  out  32  word at req_off of hit way; 0 when !hit
- miss_start  in  1  begin replacement for miss_tag; accepted only in IDLE
- miss_tag  in  TAG_WIDTH  tag to install
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after line installed
- evict_valid  out  1  evict word available
- evict_ready  in  1  bridge accepts evict word
- evict_tag  out  TAG_WIDTH  victim tag
- evict_data  out  32  victim word at word counter
- evict_last  out  1  counter == 2^OFF_WIDTH-1
- refill_valid  in  1  refill word present
- refill_ready  out  1  high exactly in REFILL
- refill_data  in  32  refill word

## Operation
- States: IDLE, EVICT, REFILL.
- IDLE: on hit & req_write, write bytes with req_be set into hit way; set dirty iff req_be != 0. Any hit makes hit_way MRU.
- IDLE & miss_start: latch miss_tag; select victim = lowest-index invalid way, else LRU way; clear word counter. Go to EVICT if victim valid & dirty, else REFILL.
- EVICT: evict_valid=1; each evict_valid&evict_ready advances counter; transfer with evict_last → counter 0, REFILL.
- REFILL: each refill_valid (refill_ready=1) writes refill_data, all bytes, to victim at counter and advances it. On last word: victim tag=latched tag, valid=1, dirty=0, victim MRU, → IDLE, done=1 next cycle.
- LRU: per-way age of log2(WAYS) bits, reset age[i]=i. Touch way w: ages < age[w] increment, age[w]=0. LRU way = max age. WAYS=1: always way 0.
- Lookups and miss_start in EVICT/REFILL ignored; hit forced 0.
- Counter wraps to 0 after 2^OFF_WIDTH-1; no other wrap.

## Timing
- Reset: all valid=0, dirty=0, tags 0, ages reset, state IDLE, counter 0; hit=0, rdata=0, busy=0, done=0, evict_valid=0, refill_ready=0. Line data not reset.
- hit/rdata: same-cycle combinational. Write-hit visible to a same-offset lookup next cycle.
- miss_start at edge N: busy=1 from cycle N+1.
- Clean miss, refill_valid held high: 2^OFF_WIDTH cycles in REFILL; done high the cycle after the last-word edge, busy=0 that cycle.
- Dirty miss: EVICT takes ≥ 2^OFF_WIDTH cycles (stalls hold evict_data/counter), then REFILL.
- rst mid-EVICT/REFILL: abort; all lines invalid; no done pulse.

## Structure
- Package cache_pkg: state encoding, OFF_WIDTH and way-index width helpers, shared with the cache controller.
- Sub-module cache_way (one per way): tag/valid/dirty registers plus 2^OFF_WIDTH×32 byte-enabled array, combinational read, synchronous reset of metadata. cache_set holds FSM, counter, LRU, hit mux.

## Test plan
- Reset, then lookup tag 0x1 off 0 → hit=0, rdata=0, busy=0.
- Clean miss tag 0x12, WAYS=2, refill words 0..15 = 0xA0+i → done after 16 accepted words; lookup 0x12 off 5 → hit=1, rdata=0xA5.
- Write-hit be=4'b0011 data 0xFFFF_FFFF on that word → rdata 0x0000_FFFF, victim later dirty.
- Fill both ways, touch way 0, miss tag 0x34 → way 1 replaced; if dirty, 16 evict words with old tag, evict_last on 16th; evict_ready low 3 cycles mid-stream holds data.
- miss_start and req_valid during REFILL ignored (hit=0); rst asserted mid-REFILL → all hit=0, busy=0 next cycle, no done.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache types: sequencer state encoding and width helpers used by the
// set and by the cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVICT  = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  // Word-offset width from log2(bytes per line), 32-bit words.
  function automatic int off_width(input int line_width);
    return line_width - 2;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: tag/valid/dirty metadata plus a byte-enabled line of
// 2^OFF_WIDTH 32-bit words with a combinational read port.
module cache_way #(
  parameter int TAG_WIDTH = 18,
  parameter int OFF_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OFF_WIDTH-1:0] rd_off,
  output logic [31:0]          rdata,
  input  logic                 wr_en,
  input  logic [OFF_WIDTH-1:0] wr_off,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_be,
  input  logic                 set_dirty,
  input  logic                 install,
  input  logic [TAG_WIDTH-1:0] install_tag,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 valid,
  output logic                 dirty
);

  logic [31:0] mem [2**OFF_WIDTH];

  // Line data is deliberately not reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_off][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rdata = mem[rd_off];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      valid <= 1'b0;
      dirty <= 1'b0;
    end else if (install) begin
      tag   <= install_tag;
      valid <= 1'b1;
      dirty <= 1'b0;
    end else if (set_dirty) begin
      dirty <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_set.sv
// N-way cache set: combinational hit lookup with write-hit, true-LRU victim
// choice, and an evict/refill sequencer streaming one word per handshake.
module cache_set
  import cache_pkg::*;
#(
  parameter int WAYS             = 2,
  parameter int CACHE_LINE_WIDTH = 6,
  parameter int TAG_WIDTH        = 18,
  localparam int OFF_WIDTH       = off_width(CACHE_LINE_WIDTH),
  localparam int IW              = idx_width(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic [OFF_WIDTH-1:0] req_off,
  input  logic                 req_write,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_be,
  output logic                 hit,
  output logic [IW-1:0]        hit_way,
  output logic [31:0]          rdata,
  input  logic                 miss_start,
  input  logic [TAG_WIDTH-1:0] miss_tag,
  output logic                 busy,
  output logic                 done,
  output logic                 evict_valid,
  input  logic                 evict_ready,
  output logic [TAG_WIDTH-1:0] evict_tag,
  output logic [31:0]          evict_data,
  output logic                 evict_last,
  input  logic                 refill_valid,
  output logic                 refill_ready,
  input  logic [31:0]          refill_data
);

  localparam logic [OFF_WIDTH-1:0] LAST = '1;

  state_t                          state, nstate;
  logic   [OFF_WIDTH-1:0]          cnt;
  logic   [IW-1:0]                 victim, vsel, touch_way;
  logic   [TAG_WIDTH-1:0]          mtag;
  logic   [WAYS-1:0][IW-1:0]       age;

  logic   [WAYS-1:0]               way_valid, way_dirty, match;
  logic   [WAYS-1:0]               wr_en, set_dirty, install;
  logic   [WAYS-1:0][TAG_WIDTH-1:0] way_tag;
  logic   [WAYS-1:0][31:0]         way_rdata;

  logic                            idle, wr_hit, refill_fire, evict_fire, last_fire, touch_en;
  logic   [OFF_WIDTH-1:0]          rd_off, wr_off;
  logic   [31:0]                   wr_data;
  logic   [3:0]                    wr_be;

  assign idle        = (state == ST_IDLE);
  assign evict_fire  = (state == ST_EVICT) && evict_ready;
  assign refill_fire = (state == ST_REFILL) && refill_valid;
  assign last_fire   = refill_fire && (cnt == LAST);
  assign wr_hit      = hit && req_write;
  assign touch_en    = hit || last_fire;
  assign touch_way   = last_fire ? victim : hit_way;

  // Lowest matching way wins; tags are unique per set in normal operation.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      match[i] = way_valid[i] && (way_tag[i] == req_tag);
      if (match[i]) hit_way = IW'(i);
    end
    hit   = req_valid && idle && (|match);
    rdata = hit ? way_rdata[hit_way] : 32'h0;
  end

  // Lowest invalid way if any, otherwise the oldest (age == WAYS-1).
  always_comb begin
    vsel = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (age[i] == IW'(WAYS - 1)) vsel = IW'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) vsel = IW'(i);
    end
  end

  // One shared write port: refill owns it in REFILL, write-hits in IDLE.
  assign rd_off  = (state == ST_EVICT)  ? cnt         : req_off;
  assign wr_off  = (state == ST_REFILL) ? cnt         : req_off;
  assign wr_data = (state == ST_REFILL) ? refill_data : req_wdata;
  assign wr_be   = (state == ST_REFILL) ? 4'hF        : req_be;

  for (genvar g = 0; g < WAYS; g++) begin : g_ctl
    assign wr_en[g]     = (wr_hit && hit_way == IW'(g)) || (refill_fire && victim == IW'(g));
    assign set_dirty[g] = wr_hit && (hit_way == IW'(g)) && (|req_be);
    assign install[g]   = last_fire && (victim == IW'(g));
  end

  cache_way #(
    .TAG_WIDTH (TAG_WIDTH),
    .OFF_WIDTH (OFF_WIDTH)
  ) u_way [WAYS-1:0] (
    .clk         (clk),
    .rst         (rst),
    .rd_off      (rd_off),
    .rdata       (way_rdata),
    .wr_en       (wr_en),
    .wr_off      (wr_off),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .set_dirty   (set_dirty),
    .install     (install),
    .install_tag (mtag),
    .tag         (way_tag),
    .valid       (way_valid),
    .dirty       (way_dirty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (miss_start)
                   nstate = (way_valid[vsel] && way_dirty[vsel]) ? ST_EVICT : ST_REFILL;
      ST_EVICT:  if (evict_ready && cnt == LAST) nstate = ST_REFILL;
      ST_REFILL: if (refill_valid && cnt == LAST) nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      victim <= '0;
      mtag   <= '0;
      done   <= 1'b0;
      for (int i = 0; i < WAYS; i++) age[i] <= IW'(i);
    end else begin
      done <= last_fire;
      if (idle && miss_start) begin
        victim <= vsel;
        mtag   <= miss_tag;
        cnt    <= '0;
      end else if (evict_fire || refill_fire) begin
        cnt <= cnt + 1'b1;
      end
      // Ages stay a permutation of 0..WAYS-1; the touched way becomes youngest.
      if (touch_en) begin
        for (int i = 0; i < WAYS; i++) begin
          if (IW'(i) == touch_way)          age[i] <= '0;
          else if (age[i] < age[touch_way]) age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  assign busy         = !idle;
  assign evict_valid  = (state == ST_EVICT);
  assign evict_tag    = way_tag[victim];
  assign evict_data   = way_rdata[victim];
  assign evict_last   = (cnt == LAST);
  assign refill_ready = (state == ST_REFILL);

endmodule
